// File: rtl/rpn_stack_calculator_16_bit.sv
// rpn_stack_calculator_16_bit: RPN token calculator driving an external LIFO through push/pop/peek strobes.
module rpn_stack_calculator_16_bit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Token_Data_In,
  input  logic                  Token_Is_Op_In,
  input  logic                  Token_Valid_In,
  output logic                  Token_Ready_Out,
  input  logic                  Clear_In,
  output logic [DATA_WIDTH-1:0] Stack_Data_Out,
  output logic                  Stack_Push_Out,
  output logic                  Stack_Pop_Out,
  output logic                  Stack_Peek_Out,
  input  logic [DATA_WIDTH-1:0] Stack_Data_In,
  input  logic                  Stack_Empty_In,
  input  logic                  Stack_Full_In,
  output logic [DATA_WIDTH-1:0] Result_Out,
  output logic                  Result_Valid_Out,
  output logic                  Error_Out,
  output logic [1:0]            Error_Code_Out
);
  typedef enum logic [3:0] {IDLE, PUSH, POP_B, CAP_B, POP_A, CAP_A, PEEK, CAP_R, DROP, ERR} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] data_q, b_q, res;
  logic [2:0] op_q;
  logic [1:0] code_n;
  logic accept;
  assign Token_Ready_Out = (state == IDLE) & ~Reset_In;
  assign accept = Token_Valid_In & Token_Ready_Out;
  assign Error_Out = state == ERR;
  assign Stack_Data_Out = data_q;
  // A arrives on Stack_Data_In during CAP_A; B was latched in CAP_B.
  assign res = op_q == 3'd0 ? Stack_Data_In + b_q :
               op_q == 3'd1 ? Stack_Data_In - b_q :
               op_q == 3'd2 ? Stack_Data_In & b_q :
               op_q == 3'd3 ? Stack_Data_In | b_q :
               op_q == 3'd4 ? Stack_Data_In ^ b_q :
               op_q == 3'd5 ? Stack_Data_In * b_q : '0;
  always_comb begin
    state_n = state;
    code_n = 2'b00;
    Stack_Push_Out = 1'b0;
    Stack_Pop_Out = 1'b0;
    Stack_Peek_Out = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (!Token_Is_Op_In) begin
          state_n = Stack_Full_In ? ERR : PUSH;
          code_n = Stack_Full_In ? 2'b01 : 2'b00;
        end else if (Stack_Empty_In) begin
          state_n = ERR;
          code_n = 2'b10;
        end else
          state_n = Token_Data_In[2:0] == 3'd6 ? PEEK : Token_Data_In[2:0] == 3'd7 ? DROP : POP_B;
      end
      PUSH: begin
        Stack_Push_Out = 1'b1;
        state_n = IDLE;
      end
      POP_B: begin
        Stack_Pop_Out = 1'b1;
        state_n = CAP_B;
      end
      CAP_B: state_n = POP_A;
      POP_A: begin
        Stack_Pop_Out = ~Stack_Empty_In;
        state_n = Stack_Empty_In ? ERR : CAP_A;
        code_n = Stack_Empty_In ? 2'b10 : 2'b00;
      end
      CAP_A: state_n = PUSH;
      PEEK: begin
        Stack_Peek_Out = 1'b1;
        state_n = CAP_R;
      end
      CAP_R: state_n = IDLE;
      DROP: begin
        Stack_Pop_Out = 1'b1;
        state_n = IDLE;
      end
      ERR: state_n = Clear_In ? IDLE : ERR;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= IDLE;
      data_q <= '0;
      b_q <= '0;
      op_q <= '0;
      Result_Out <= '0;
      Result_Valid_Out <= 1'b0;
      Error_Code_Out <= 2'b00;
    end else begin
      state <= state_n;
      Result_Valid_Out <= state == CAP_R;
      if (accept && !Token_Is_Op_In) data_q <= Token_Data_In;
      if (accept && Token_Is_Op_In) op_q <= Token_Data_In[2:0];
      if (state == CAP_B) b_q <= Stack_Data_In;
      if (state == CAP_A) data_q <= res;
      if (state == CAP_R) Result_Out <= Stack_Data_In;
      if (state_n == ERR && state != ERR) Error_Code_Out <= code_n;
      else if (state == ERR && Clear_In) Error_Code_Out <= 2'b00;
    end
  end
endmodule

// File: tb/tb_rpn_stack_calculator_16_bit.sv
// tb_rpn_stack_calculator_16_bit: directed and random token streams against a queue-based RPN model.
module tb_rpn_stack_calculator_16_bit;
  logic        Clk_In = 0, Reset_In = 1;
  logic [15:0] Token_Data_In = 0;
  logic        Token_Is_Op_In = 0, Token_Valid_In = 0, Clear_In = 0;
  logic [15:0] Stack_Data_Out, Result_Out;
  logic        Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out, Token_Ready_Out;
  logic        Result_Valid_Out, Error_Out;
  logic [1:0]  Error_Code_Out;
  logic [15:0] lifo_dout = 0;
  logic [15:0] lq[$];
  int          lcnt = 0;
  logic        Stack_Empty_In, Stack_Full_In;
  int checks = 0, errors = 0;
  int push_cnt = 0, rv_cnt = 0;
  logic [15:0] last_push = 0, rv_val = 0;
  int mq[$];
  logic [15:0] m_result = 0;

  assign Stack_Empty_In = lcnt == 0;
  assign Stack_Full_In = lcnt == 8;

  rpn_stack_calculator_16_bit #(.DATA_WIDTH(16)) dut (
    .Clk_In(Clk_In), .Reset_In(Reset_In), .Token_Data_In(Token_Data_In),
    .Token_Is_Op_In(Token_Is_Op_In), .Token_Valid_In(Token_Valid_In),
    .Token_Ready_Out(Token_Ready_Out), .Clear_In(Clear_In),
    .Stack_Data_Out(Stack_Data_Out), .Stack_Push_Out(Stack_Push_Out),
    .Stack_Pop_Out(Stack_Pop_Out), .Stack_Peek_Out(Stack_Peek_Out),
    .Stack_Data_In(lifo_dout), .Stack_Empty_In(Stack_Empty_In),
    .Stack_Full_In(Stack_Full_In), .Result_Out(Result_Out),
    .Result_Valid_Out(Result_Valid_Out), .Error_Out(Error_Out),
    .Error_Code_Out(Error_Code_Out)
  );

  always #5 Clk_In = ~Clk_In;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8-deep LIFO environment; read data appears the cycle after pop/peek
  always @(posedge Clk_In) begin
    if (Reset_In) begin
      lq.delete();
      lcnt <= 0;
      lifo_dout <= 0;
    end else if (Stack_Push_Out) begin
      if (lq.size() < 8) lq.push_back(Stack_Data_Out);
      lcnt <= lq.size();
    end else if (Stack_Pop_Out) begin
      if (lq.size() > 0) lifo_dout <= lq.pop_back();
      lcnt <= lq.size();
    end else if (Stack_Peek_Out && lq.size() > 0)
      lifo_dout <= lq[$];
  end

  always @(negedge Clk_In) begin
    chk("strobe_onehot", 32'($countones({Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out}) <= 1), 1);
    if (Stack_Push_Out) begin
      push_cnt++;
      last_push = Stack_Data_Out;
      chk("push_not_full", 32'(lcnt < 8), 1);
    end
    if (Stack_Pop_Out) chk("pop_not_empty", 32'(lcnt > 0), 1);
    if (Result_Valid_Out) begin
      rv_cnt++;
      rv_val = Result_Out;
    end
  end

  function automatic logic [15:0] alu(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int unsigned p;
    p = a * b;
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return p[15:0];
    endcase
  endfunction

  task automatic tok(input logic is_op, input logic [15:0] d);
    int pc0, rc0, n, lat, exp_lat;
    bit err, do_push, do_peek;
    logic [1:0] code;
    logic [15:0] a, b, r;
    pc0 = push_cnt; rc0 = rv_cnt; err = 0; code = 0; do_push = 0; do_peek = 0; exp_lat = 0; r = 0;
    if (!is_op) begin
      if (mq.size() == 8) begin err = 1; code = 2'b01; end
      else begin mq.push_back(d); do_push = 1; r = d; exp_lat = 2; end
    end else if (mq.size() == 0) begin
      err = 1; code = 2'b10;
    end else if (d[2:0] == 3'd6) begin
      do_peek = 1; r = 16'(mq[$]); exp_lat = 3;
    end else if (d[2:0] == 3'd7) begin
      void'(mq.pop_back()); exp_lat = 2;
    end else begin
      b = 16'(mq.pop_back());
      if (mq.size() == 0) begin err = 1; code = 2'b10; end
      else begin
        a = 16'(mq.pop_back());
        r = alu(d[2:0], a, b);
        mq.push_back(r); do_push = 1; exp_lat = 6;
      end
    end
    n = 0;
    @(negedge Clk_In);
    while (!Token_Ready_Out && n < 20) begin @(negedge Clk_In); n++; end
    chk("ready_before_token", Token_Ready_Out, 1);
    Token_Data_In = d; Token_Is_Op_In = is_op; Token_Valid_In = 1;
    @(posedge Clk_In);
    #1 Token_Valid_In = 0; Token_Data_In = 16'($urandom);
    lat = 0;
    while (lat < 30) begin
      @(negedge Clk_In);
      lat++;
      if (Token_Ready_Out || Error_Out) break;
    end
    #1;
    chk("error_out", Error_Out, err);
    chk("error_code", Error_Code_Out, code);
    if (err) chk("ready_in_error", Token_Ready_Out, 0);
    else chk("latency", lat, exp_lat);
    chk("push_count", push_cnt - pc0, do_push);
    if (do_push) chk("push_data", last_push, r);
    if (do_peek) m_result = r;
    chk("result_valid_pulses", rv_cnt - rc0, do_peek);
    chk("result_out", Result_Out, m_result);
    chk("stack_depth", lcnt, mq.size());
  endtask

  task automatic clear_err();
    @(negedge Clk_In) Clear_In = 1;
    @(negedge Clk_In) Clear_In = 0;
    chk("clear_error_out", Error_Out, 0);
    chk("clear_error_code", Error_Code_Out, 0);
    chk("clear_ready", Token_Ready_Out, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int pc0;
    repeat (3) @(negedge Clk_In);
    chk("rst_ready", Token_Ready_Out, 0);
    chk("rst_strobes", {Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out}, 0);
    chk("rst_result", {Result_Out, Result_Valid_Out}, 0);
    chk("rst_error", {Error_Out, Error_Code_Out}, 0);
    chk("rst_data", Stack_Data_Out, 0);
    Reset_In = 0;
    tok(0, 16'h0003); tok(0, 16'h0004); tok(1, 16'h0000); tok(1, 16'h0006);
    chk("add_result", rv_val, 16'h0007);
    tok(1, 16'h0007);
    tok(0, 16'h000A); tok(0, 16'h0003); tok(1, 16'h0001); tok(1, 16'h0006); tok(1, 16'h0007);
    tok(0, 16'h0003); tok(0, 16'h000A); tok(1, 16'h0001); tok(1, 16'h0006); tok(1, 16'h0007);
    chk("sub_wrap", Result_Out, 16'hFFF9);
    tok(0, 16'h0100); tok(0, 16'h0100); tok(1, 16'h0005); tok(1, 16'h0006); tok(1, 16'h0007);
    chk("mul_low", Result_Out, 16'h0000);
    tok(0, 16'h00F0); tok(0, 16'h0F0F); tok(1, 16'h0004); tok(1, 16'h0006); tok(1, 16'h0007);
    chk("xor", Result_Out, 16'h0FFF);
    for (int i = 0; i < 8; i++) tok(0, 16'h1000 + 16'(i));
    chk("full_flag", Stack_Full_In, 1);
    tok(0, 16'hBEEF);
    clear_err();
    tok(1, 16'h0006);
    chk("peek_8th", Result_Out, 16'h1007);
    for (int i = 0; i < 8; i++) tok(1, 16'h0007);
    tok(0, 16'h0005); tok(1, 16'h0000);
    clear_err();
    tok(1, 16'h0006);
    clear_err();
    tok(1, 16'h0007);
    clear_err();
    tok(0, 16'h0001); tok(0, 16'h0002);
    @(negedge Clk_In);
    Token_Data_In = 16'h0000; Token_Is_Op_In = 1; Token_Valid_In = 1;
    @(posedge Clk_In);
    #1 Token_Valid_In = 0;
    repeat (3) @(posedge Clk_In);
    #1 Reset_In = 1;
    #1;
    pc0 = push_cnt;
    chk("midrst_strobes", {Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out}, 0);
    chk("midrst_ready", Token_Ready_Out, 0);
    chk("midrst_outputs", {Result_Out, Result_Valid_Out, Error_Out, Error_Code_Out, Stack_Data_Out}, 0);
    @(negedge Clk_In);
    @(negedge Clk_In) Reset_In = 0;
    repeat (8) @(negedge Clk_In);
    chk("midrst_no_push", push_cnt - pc0, 0);
    chk("midrst_ready_after", Token_Ready_Out, 1);
    mq.delete();
    m_result = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 5) tok(0, 16'($urandom));
      else tok(1, 16'($urandom));
      if (Error_Out) clear_err();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rpn_stack_calculator_16_bit.md
Name: rpn_stack_calculator_16_bit

Overview:
- Reverse-Polish integer calculator and command-side master for the 16-bit LIFO stack.
- Accepts a stream of operand/operator tokens over a valid/ready handshake.
- Drives the stack's Push/Pop/Peek inputs and consumes its Data_Out, Empty and Full outputs.
- Sits between a token source (UART/command decoder) and an external 8-deep LIFO instance.

Parameters:
- DATA_WIDTH, 16, width of operands, results and stack data.

Ports:
- Clk_In  input  1  system clock, rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Token_Data_In  input  DATA_WIDTH  operand value, or opcode in [2:0] when Token_Is_Op_In=1.
- Token_Is_Op_In  input  1  1 = operator token, 0 = operand token.
- Token_Valid_In  input  1  token present.
- Token_Ready_Out  output  1  block can accept a token this cycle.
- Clear_In  input  1  clears the sticky error.
- Stack_Data_Out  output  DATA_WIDTH  to LIFO Data_In.
- Stack_Push_Out  output  1  to LIFO Push_In.
- Stack_Pop_Out  output  1  to LIFO Pop_In.
- Stack_Peek_Out  output  1  to LIFO Peek_In.
- Stack_Data_In  input  DATA_WIDTH  from LIFO Data_Out; valid the cycle after a Pop/Peek strobe.
- Stack_Empty_In  input  1  from LIFO_Empty.
- Stack_Full_In  input  1  from LIFO_Full.
- Result_Out  output  DATA_WIDTH  last peeked top-of-stack.
- Result_Valid_Out  output  1  one-cycle pulse when Result_Out updates.
- Error_Out  output  1  sticky error flag.
- Error_Code_Out  output  2  01 overflow, 10 underflow, 00 none.

Behaviour:
- Reset: every output 0; FSM enters IDLE. Asserting reset mid-sequence aborts the operation at once, with no further strobes.
- Interface rule: at most one of Push/Pop/Peek is high per cycle. Each strobe lasts exactly one cycle.
- Token transfer: a token is accepted when Token_Valid_In & Token_Ready_Out are high at a rising edge.
- Token_Ready_Out=1 only in IDLE with Error_Out=0.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 PEEK, 7 DROP.
- Binary operators: B = first pop (top of stack), A = second pop. The pushed result is A op B.
- Arithmetic: modulo 2^16. SUB wraps. MUL keeps the low 16 bits of the 32-bit product.
- Operand token:
  - If Stack_Full_In=1 at acceptance: error 01, no push.
  - Otherwise: PUSH state, Stack_Push_Out=1 with Stack_Data_Out=value, back to IDLE.
  - Latency: accept cycle + 1.
- Binary operator sequence:
  - IDLE: if Stack_Empty_In=1, error 10.
  - POP_B: Stack_Pop_Out=1.
  - CAP_B: latch B from Stack_Data_In.
  - POP_A: if Stack_Empty_In=1, error 10 (B is discarded; stack stays empty); otherwise Stack_Pop_Out=1.
  - CAP_A: latch A.
  - PUSH: Stack_Push_Out=1 with the result.
  - IDLE.
  - Total 6 cycles from acceptance to Ready.
- PEEK:
  - If empty: error 10.
  - Otherwise PEEK state (Stack_Peek_Out=1), then CAP_R (Result_Out <= Stack_Data_In, Result_Valid_Out=1), then IDLE.
  - Stack contents are unchanged.
- DROP:
  - If empty: error 10.
  - Otherwise one Pop strobe; the data is ignored.
- Error state ERR:
  - Error_Out=1 with the code held.
  - Token_Ready_Out=0 and no stack strobes.
  - Clear_In=1 in ERR: Error_Out and Error_Code_Out return to 0 next cycle; FSM goes to IDLE.
  - Clear_In outside ERR has no effect.
- Result_Out holds its value between peeks. It is not changed by errors; only reset clears it.
- Token_Valid_In while Ready=0 is ignored. The source must hold the token until it is accepted.

Test Plan:
- Reset, push 3, push 4, ADD, PEEK -> push of 0x0007 six cycles after the ADD is accepted; Result_Out=0x0007 with a one-cycle Result_Valid_Out; the stack then holds 1 entry.
- Push 0x000A, push 0x0003, SUB, PEEK -> Result_Out=0x0007. Push 0x0003, push 0x000A, SUB, PEEK -> Result_Out=0xFFF9.
- Push 0x0100, push 0x0100, MUL, PEEK -> Result_Out=0x0000. Push 0x00F0, push 0x0F0F, XOR, PEEK -> 0x0FFF.
- Push 8 operands until Stack_Full_In=1, then a 9th operand 0xBEEF -> no Stack_Push_Out; Error_Out=1, code 01; Ready=0; pulse Clear_In -> Ready=1; PEEK returns the 8th operand.
- Empty stack: push 0x0005, ADD -> one Pop strobe, then error code 10 with no push; Clear_In; PEEK -> error 10 (stack empty). Clear_In; DROP on empty -> error 10.
- Assert Reset_In during CAP_A of an ADD -> all outputs 0 the same cycle; no Push strobe follows; Ready=1 after release.
